// File: rtl/arm_task_scheduler_if.sv
// Command channel between the task scheduler and the arm executor.
// The scheduler is the master: it offers a zone with cmd_valid/cmd_zone,
// the executor accepts with cmd_ready and reports completion with arm_done.
interface arm_task_scheduler_if;
    logic       cmd_valid;
    logic [2:0] cmd_zone;
    logic       cmd_ready;
    logic       arm_done;

    modport master (
        output cmd_valid,
        output cmd_zone,
        input  cmd_ready,
        input  arm_done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_zone,
        output cmd_ready,
        output arm_done
    );
endinterface

// File: rtl/arm_task_scheduler.sv
// Zone pick scheduler: queues key and vision requests in a small FIFO and
// dispatches them one at a time to the arm executor. Each dispatch waits
// for a done pulse or a timeout. Drives the zone LEDs and zone bits of the
// task currently in flight.
module arm_task_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 74250000,
    parameter int CNT_W   = 31
) (
    input  logic                   hdmi_clk1x_i,
    input  logic                   rst_n,
    input  logic                   key_req,
    input  logic [2:0]             key_zone,
    input  logic                   vis_valid,
    input  logic [2:0]             vis_zone,
    output logic                   vis_ready,
    input  logic                   abort,
    arm_task_scheduler_if.master   cmd_if,
    output logic [7:0]             led,
    output logic [2:0]             zone_out,
    output logic                   busy,
    output logic                   timeout_err,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] q_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [2:0]       mem_q [DEPTH];
    logic [2:0]       cur_zone_q, cur_zone_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [7:0]       led_q, led_d;
    logic [2:0]       zone_q, zone_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic             overflow_q, overflow_d;

    logic             full, empty, push, pop;
    logic [2:0]       push_zone;

    // FIFO status, enqueue arbitration (key before vision) and pointer update;
    // full is judged before any same-cycle pop, abort flushes by snapping rd to wr
    always_comb begin
        full      = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        empty     = (wr_q == rd_q);
        vis_ready = !full && !key_req && !abort;
        push      = !abort && ((key_req && !full) || (vis_valid && vis_ready));
        push_zone = key_req ? key_zone : vis_zone;
        pop       = (state_q == IDLE) && !empty && !abort;
        wr_d      = wr_q + {{AW{1'b0}}, push};
        rd_d      = rd_q + {{AW{1'b0}}, pop};
        if (abort) begin
            wr_d = wr_q;
            rd_d = wr_q;
        end
    end

    // Queue storage; contents need no reset because the pointers say what is valid
    always_ff @(posedge hdmi_clk1x_i) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= push_zone;
        end
    end

    // Next-state logic: pop into ISSUE, handshake into EXEC, done or timeout back to IDLE
    always_comb begin
        state_d    = state_q;
        cur_zone_d = cur_zone_q;
        cnt_d      = '0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    cur_zone_d = mem_q[rd_q[AW-1:0]];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_if.cmd_ready) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cmd_if.arm_done || (cnt_q == CNT_TERM)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Output decode from the next state so outputs change together with the state
    always_comb begin
        cmd_valid_d = (state_d == ISSUE);
        busy_d      = (state_d == ISSUE) || (state_d == EXEC);
        led_d       = busy_d ? (8'd1 << cur_zone_d) : 8'd0;
        zone_d      = busy_d ? cur_zone_d : 3'd0;
        timeout_d   = (state_q == EXEC) && !cmd_if.arm_done && (cnt_q == CNT_TERM) && !abort;
        overflow_d  = key_req && full;
    end

    // State, pointers, counter and registered outputs
    always_ff @(posedge hdmi_clk1x_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_q        <= '0;
            rd_q        <= '0;
            cur_zone_q  <= '0;
            cnt_q       <= '0;
            cmd_valid_q <= 1'b0;
            led_q       <= '0;
            zone_q      <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cur_zone_q  <= cur_zone_d;
            cnt_q       <= cnt_d;
            cmd_valid_q <= cmd_valid_d;
            led_q       <= led_d;
            zone_q      <= zone_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            overflow_q  <= overflow_d;
        end
    end

    assign cmd_if.cmd_valid = cmd_valid_q;
    assign cmd_if.cmd_zone  = cur_zone_q;
    assign led              = led_q;
    assign zone_out         = zone_q;
    assign busy             = busy_q;
    assign timeout_err      = timeout_q;
    assign overflow         = overflow_q;
    assign q_level          = wr_q - rd_q;

endmodule

// File: tb/tb_arm_task_scheduler.sv
// Self-checking bench for arm_task_scheduler with DEPTH=4 and TIMEOUT=20.
// A cycle table covers the single-task and priority flows; hand-written
// sequences cover full/overflow, abort, timeout and asynchronous reset.
module tb_arm_task_scheduler;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 20;
    localparam int CNT_W   = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_req;
    logic [2:0] key_zone;
    logic       vis_valid;
    logic [2:0] vis_zone;
    logic       vis_ready;
    logic       abort;
    logic [7:0] led;
    logic [2:0] zone_out;
    logic       busy;
    logic       timeout_err;
    logic       overflow;
    logic [2:0] q_level;

    int errors = 0;
    int checks = 0;

    arm_task_scheduler_if cmdIf();

    arm_task_scheduler #(
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .hdmi_clk1x_i(clk),
        .rst_n       (rst_n),
        .key_req     (key_req),
        .key_zone    (key_zone),
        .vis_valid   (vis_valid),
        .vis_zone    (vis_zone),
        .vis_ready   (vis_ready),
        .abort       (abort),
        .cmd_if      (cmdIf.master),
        .led         (led),
        .zone_out    (zone_out),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overflow    (overflow),
        .q_level     (q_level)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    typedef struct {
        logic       kr;
        logic [2:0] kz;
        logic       vv;
        logic [2:0] vz;
        logic       rdy;
        logic       done;
        logic       eCv;
        logic [2:0] eCz;
        logic [7:0] eLed;
        logic [2:0] eZone;
        logic       eBusy;
        logic       eVr;
        logic [2:0] eLvl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic kr, logic [2:0] kz, logic vv, logic [2:0] vz,
                                logic rdy, logic done, logic eCv, logic [2:0] eCz,
                                logic [7:0] eLed, logic [2:0] eZone, logic eBusy,
                                logic eVr, logic [2:0] eLvl);
        vec_t v;
        v.kr = kr;  v.kz = kz;  v.vv = vv;  v.vz = vz;  v.rdy = rdy; v.done = done;
        v.eCv = eCv; v.eCz = eCz; v.eLed = eLed; v.eZone = eZone;
        v.eBusy = eBusy; v.eVr = eVr; v.eLvl = eLvl;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        key_req          = v.kr;
        key_zone         = v.kz;
        vis_valid        = v.vv;
        vis_zone         = v.vz;
        cmdIf.cmd_ready  = v.rdy;
        cmdIf.arm_done   = v.done;
        abort            = 1'b0;
    endtask

    task automatic waitExec(output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (busy && !cmdIf.cmd_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Overall time limit so the run can never hang
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic       ok;
        logic       seen;
        logic [2:0] zl [5];
        int         n;

        rst_n = 1'b0;
        key_req = 1'b0; key_zone = 3'd0; vis_valid = 1'b0; vis_zone = 3'd0;
        abort = 1'b0; cmdIf.cmd_ready = 1'b0; cmdIf.arm_done = 1'b0;

        // reset state
        #7;
        checkOutput("rst_cmd_valid", 32'(cmdIf.cmd_valid), 32'd0);
        checkOutput("rst_busy",      32'(busy),            32'd0);
        checkOutput("rst_led",       32'(led),             32'd0);
        checkOutput("rst_q_level",   32'(q_level),         32'd0);
        checkOutput("rst_vis_ready", 32'(vis_ready),       32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // single task: vision zone 5, cmd_ready high, arm_done at cycle 10
        vecs.push_back(mk(1'b0,3'd0,1'b1,3'd5,1'b1,1'b0, 1'b0,3'd0,8'h00,3'd0,1'b0,1'b1,3'd0));
        vecs.push_back(mk(1'b0,3'd0,1'b0,3'd0,1'b1,1'b0, 1'b0,3'd0,8'h00,3'd0,1'b0,1'b1,3'd1));
        vecs.push_back(mk(1'b0,3'd0,1'b0,3'd0,1'b1,1'b0, 1'b1,3'd5,8'h20,3'd5,1'b1,1'b1,3'd0));
        for (int i = 3; i <= 9; i++)
            vecs.push_back(mk(1'b0,3'd0,1'b0,3'd0,1'b1,1'b0, 1'b0,3'd0,8'h20,3'd5,1'b1,1'b1,3'd0));
        vecs.push_back(mk(1'b0,3'd0,1'b0,3'd0,1'b1,1'b1, 1'b0,3'd0,8'h20,3'd5,1'b1,1'b1,3'd0));
        vecs.push_back(mk(1'b0,3'd0,1'b0,3'd0,1'b1,1'b0, 1'b0,3'd0,8'h00,3'd0,1'b0,1'b1,3'd0));
        // priority: key zone 2 and vision zone 6 together
        vecs.push_back(mk(1'b1,3'd2,1'b1,3'd6,1'b1,1'b0, 1'b0,3'd0,8'h00,3'd0,1'b0,1'b0,3'd0));
        vecs.push_back(mk(1'b0,3'd0,1'b1,3'd6,1'b1,1'b0, 1'b0,3'd0,8'h00,3'd0,1'b0,1'b1,3'd1));
        vecs.push_back(mk(1'b0,3'd0,1'b0,3'd0,1'b1,1'b0, 1'b1,3'd2,8'h04,3'd2,1'b1,1'b1,3'd1));
        vecs.push_back(mk(1'b0,3'd0,1'b0,3'd0,1'b1,1'b1, 1'b0,3'd0,8'h04,3'd2,1'b1,1'b1,3'd1));
        vecs.push_back(mk(1'b0,3'd0,1'b0,3'd0,1'b1,1'b0, 1'b0,3'd0,8'h00,3'd0,1'b0,1'b1,3'd1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("row%0d_cmd_valid", i), 32'(cmdIf.cmd_valid), 32'(vecs[i].eCv));
            if (vecs[i].eCv)
                checkOutput($sformatf("row%0d_cmd_zone", i), 32'(cmdIf.cmd_zone), 32'(vecs[i].eCz));
            checkOutput($sformatf("row%0d_led", i),       32'(led),         32'(vecs[i].eLed));
            checkOutput($sformatf("row%0d_zone_out", i),  32'(zone_out),    32'(vecs[i].eZone));
            checkOutput($sformatf("row%0d_busy", i),      32'(busy),        32'(vecs[i].eBusy));
            checkOutput($sformatf("row%0d_vis_ready", i), 32'(vis_ready),   32'(vecs[i].eVr));
            checkOutput($sformatf("row%0d_q_level", i),   32'(q_level),     32'(vecs[i].eLvl));
            checkOutput($sformatf("row%0d_timeout", i),   32'(timeout_err), 32'd0);
            checkOutput($sformatf("row%0d_overflow", i),  32'(overflow),    32'd0);
            tick();
        end

        // the queued vision zone 6 is dispatched second
        n = 0;
        while (!cmdIf.cmd_valid && n < 6) begin
            tick();
            n++;
        end
        checkOutput("prio_second_valid", 32'(cmdIf.cmd_valid), 32'd1);
        checkOutput("prio_second_zone",  32'(cmdIf.cmd_zone),  32'd6);
        checkOutput("prio_second_led",   32'(led),             32'h40);
        tick();
        cmdIf.arm_done = 1'b1;
        tick();
        cmdIf.arm_done = 1'b0;
        checkOutput("prio_done_busy",    32'(busy),    32'd0);
        checkOutput("prio_done_q_level", 32'(q_level), 32'd0);

        // full and overflow: stalled arm, key pushes 1,2,3,4,7
        zl[0] = 3'd1; zl[1] = 3'd2; zl[2] = 3'd3; zl[3] = 3'd4; zl[4] = 3'd7;
        cmdIf.cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            key_req = 1'b1;
            key_zone = zl[i];
            tick();
            if (i == 3) begin
                checkOutput("full_issue_valid", 32'(cmdIf.cmd_valid), 32'd1);
                checkOutput("full_issue_zone",  32'(cmdIf.cmd_zone),  32'd1);
                checkOutput("full_level3",      32'(q_level),         32'd3);
            end
        end
        checkOutput("full_level4", 32'(q_level), 32'd4);
        key_zone = 3'd5;
        vis_valid = 1'b1;
        vis_zone = 3'd6;
        tick();
        key_req = 1'b0;
        #1;
        checkOutput("ovf_pulse",      32'(overflow),  32'd1);
        checkOutput("ovf_level",      32'(q_level),   32'd4);
        checkOutput("full_vis_ready", 32'(vis_ready), 32'd0);
        tick();
        checkOutput("ovf_single",     32'(overflow),        32'd0);
        checkOutput("full_vis_stall", 32'(q_level),         32'd4);
        checkOutput("full_zone_hold", 32'(cmdIf.cmd_zone),  32'd1);

        // abort while a task waits in ISSUE with a full queue
        vis_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort1_q_level",   32'(q_level),         32'd0);
        checkOutput("abort1_cmd_valid", 32'(cmdIf.cmd_valid), 32'd0);
        checkOutput("abort1_busy",      32'(busy),            32'd0);

        // abort with three queued entries and one task in EXEC
        for (int i = 0; i < 4; i++) begin
            key_req = 1'b1;
            key_zone = zl[i];
            tick();
        end
        key_req = 1'b0;
        cmdIf.cmd_ready = 1'b1;
        tick();
        checkOutput("abort2_exec_busy",  32'(busy),            32'd1);
        checkOutput("abort2_exec_valid", 32'(cmdIf.cmd_valid), 32'd0);
        checkOutput("abort2_exec_level", 32'(q_level),         32'd3);
        abort = 1'b1;
        key_req = 1'b1;
        key_zone = 3'd5;
        tick();
        abort = 1'b0;
        key_req = 1'b0;
        checkOutput("abort2_q_level",  32'(q_level),         32'd0);
        checkOutput("abort2_busy",     32'(busy),            32'd0);
        checkOutput("abort2_led",      32'(led),             32'd0);
        checkOutput("abort2_zone_out", 32'(zone_out),        32'd0);
        checkOutput("abort2_valid",    32'(cmdIf.cmd_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cmdIf.cmd_valid || busy || timeout_err) seen = 1'b1;
        end
        checkOutput("abort2_stays_idle", 32'(seen), 32'd0);

        // timeout: task accepted, no arm_done
        key_req = 1'b1;
        key_zone = 3'd3;
        tick();
        key_req = 1'b0;
        waitExec(ok);
        checkOutput("to_exec_reached", 32'(ok), 32'd1);
        seen = 1'b0;
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            if (timeout_err || !busy) seen = 1'b1;
        end
        checkOutput("to_no_early", 32'(seen), 32'd0);
        tick();
        checkOutput("to_pulse",     32'(timeout_err), 32'd1);
        checkOutput("to_busy_drop", 32'(busy),        32'd0);
        tick();
        checkOutput("to_single", 32'(timeout_err), 32'd0);

        // arm_done on the terminal count wins over the timeout
        key_req = 1'b1;
        key_zone = 3'd4;
        tick();
        key_req = 1'b0;
        waitExec(ok);
        checkOutput("tc_exec_reached", 32'(ok), 32'd1);
        for (int k = 1; k < TIMEOUT; k++) tick();
        cmdIf.arm_done = 1'b1;
        tick();
        cmdIf.arm_done = 1'b0;
        checkOutput("tc_no_timeout", 32'(timeout_err), 32'd0);
        checkOutput("tc_busy_drop",  32'(busy),        32'd0);
        tick();
        checkOutput("tc_no_timeout_late", 32'(timeout_err), 32'd0);

        // asynchronous reset in the middle of EXEC with one entry queued
        key_req = 1'b1;
        key_zone = 3'd6;
        tick();
        key_zone = 3'd7;
        tick();
        key_req = 1'b0;
        waitExec(ok);
        checkOutput("rstx_exec_reached", 32'(ok), 32'd1);
        checkOutput("rstx_pre_level",    32'(q_level), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstx_busy",      32'(busy),            32'd0);
        checkOutput("rstx_led",       32'(led),             32'd0);
        checkOutput("rstx_zone_out",  32'(zone_out),        32'd0);
        checkOutput("rstx_cmd_valid", 32'(cmdIf.cmd_valid), 32'd0);
        checkOutput("rstx_q_level",   32'(q_level),         32'd0);
        checkOutput("rstx_timeout",   32'(timeout_err),     32'd0);
        checkOutput("rstx_overflow",  32'(overflow),        32'd0);
        checkOutput("rstx_vis_ready", 32'(vis_ready),       32'd1);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (cmdIf.cmd_valid || busy || (q_level != 3'd0)) seen = 1'b1;
        end
        checkOutput("rstx_idle_after", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
